// File: rtl/fram_stream_pkg.sv
// fram_stream_pkg: state encoding, direction codes and drain timing for the fram stream port
package fram_stream_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, DUMP, DRAIN} state_t;
    localparam logic DIR_LOAD = 1'b0;
    localparam logic DIR_DUMP = 1'b1;
    localparam int DRAIN_CYCLES = 2;
    function automatic int unsigned wrap_inc(input int unsigned a, input int unsigned size);
        return (a == size - 1) ? 0 : a + 1;
    endfunction
endpackage

// File: rtl/fram_skid_fifo.sv
// fram_skid_fifo: 2-entry FIFO catching read data that returns while the dump stream is stalled
module fram_skid_fifo #(
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem [2];
    logic wp, rp;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            count <= count + 2'(push) - 2'(pop);
        end
    end
    assign dout = mem[rp];
endmodule

// File: rtl/fram_stream_port.sv
// fram_stream_port: moves blocks between valid/ready streams and a pu_fram-style memory
module fram_stream_port
    import fram_stream_pkg::*;
#(
    parameter int RAM_SIZE   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [ATTR_WIDTH-1:0] s_attr,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ATTR_WIDTH-1:0] m_attr,
    output logic [ADDR_WIDTH-1:0] signal_addr,
    output logic                  signal_wr,
    output logic                  signal_oe,
    output logic [DATA_WIDTH-1:0] fram_data_in,
    output logic [ATTR_WIDTH-1:0] fram_attr_in,
    input  logic [DATA_WIDTH-1:0] fram_data_out,
    input  logic [ATTR_WIDTH-1:0] fram_attr_out,
    output logic                  busy,
    output logic                  done
);
    localparam logic [ADDR_WIDTH:0] ONE = 1;

    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] addr, addr_nx, addr_inc;
    logic [ADDR_WIDTH:0] rem, rem_nx, pops, pops_nx;
    logic [1:0] wait_cnt, wait_nx, count;
    logic [2:0] credit;
    logic inflight, issue, pop, wr_beat;

    assign cmd_ready    = state == IDLE;
    assign busy         = state != IDLE;
    assign s_ready      = state == LOAD;
    assign wr_beat      = s_ready && s_valid;
    assign signal_wr    = wr_beat;
    assign signal_oe    = issue;
    assign signal_addr  = (s_ready || state == DUMP) ? addr : '0;
    assign fram_data_in = s_data;
    assign fram_attr_in = s_attr;
    assign addr_inc     = ADDR_WIDTH'(wrap_inc(32'(addr), RAM_SIZE));
    assign m_valid      = count != 2'd0;
    assign pop          = m_valid && m_ready;
    // A pop this cycle frees a slot, so a read may issue into the space it leaves
    assign credit       = 3'(count) + 3'(inflight) - 3'(pop);
    assign issue        = state == DUMP && rem != '0 && count != 2'd2 && credit < 3'd2;

    fram_skid_fifo #(.WIDTH(DATA_WIDTH + ATTR_WIDTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .pop   (pop),
        .din   ({fram_data_out, fram_attr_out}),
        .dout  ({m_data, m_attr}),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr     <= '0;
            rem      <= '0;
            pops     <= '0;
            wait_cnt <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nx;
            addr     <= addr_nx;
            rem      <= rem_nx;
            pops     <= pops_nx;
            wait_cnt <= wait_nx;
            inflight <= issue;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        rem_nx   = rem;
        pops_nx  = pops;
        wait_nx  = wait_cnt;
        done     = 1'b0;
        case (state)
            IDLE: if (cmd_valid) begin
                addr_nx  = cmd_base;
                rem_nx   = cmd_len;
                pops_nx  = cmd_len;
                wait_nx  = '0;
                state_nx = (cmd_len == '0) ? DRAIN : (cmd_dir == DIR_DUMP) ? DUMP : LOAD;
            end
            LOAD: if (wr_beat) begin
                addr_nx = addr_inc;
                rem_nx  = rem - ONE;
                if (rem == ONE) begin
                    state_nx = DRAIN;
                    wait_nx  = 2'(DRAIN_CYCLES - 1);
                end
            end
            DUMP: begin
                if (issue) begin
                    addr_nx = addr_inc;
                    rem_nx  = rem - ONE;
                end
                if (pop) begin
                    pops_nx = pops - ONE;
                    if (pops == ONE) begin
                        done     = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            DRAIN: begin
                done     = wait_cnt == 2'd0;
                state_nx = done ? IDLE : DRAIN;
                wait_nx  = done ? wait_cnt : wait_cnt - 2'd1;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fram_stream_port.sv
// tb_fram_stream_port: randomized scoreboard bench with a word-level memory reference model
module tb_fram_stream_port;
    localparam int RS = 16, DW = 32, AW = 4, ADW = $clog2(RS);
    localparam int WW = DW + AW;

    logic clk = 1'b0, rst_n = 1'b1;
    logic cmd_valid = 1'b0, cmd_dir = 1'b0, cmd_ready;
    logic [ADW-1:0] cmd_base = '0;
    logic [ADW:0] cmd_len = '0;
    logic s_valid = 1'b0, s_ready;
    logic [DW-1:0] s_data = '0;
    logic [AW-1:0] s_attr = '0;
    logic m_valid, m_ready = 1'b1;
    logic [DW-1:0] m_data, fram_data_in, fram_data_out = '0;
    logic [AW-1:0] m_attr, fram_attr_in, fram_attr_out = '0;
    logic [ADW-1:0] signal_addr;
    logic signal_wr, signal_oe, busy, done;

    int checks = 0, errors = 0, cyc = 0, rdy_mode = 0, last_wr_cyc = 0, occ = 0, infl = 0;
    logic [WW-1:0] ref_mem [RS];
    logic [WW-1:0] exp_q [$];
    logic [ADW+WW-1:0] wq [$];

    fram_stream_port #(.RAM_SIZE(RS), .DATA_WIDTH(DW), .ATTR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_base(cmd_base), .cmd_len(cmd_len), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_attr(s_attr), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_attr(m_attr),
        .signal_addr(signal_addr), .signal_wr(signal_wr), .signal_oe(signal_oe),
        .fram_data_in(fram_data_in), .fram_attr_in(fram_attr_in), .fram_data_out(fram_data_out),
        .fram_attr_out(fram_attr_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory with a registered write (commits one edge after the strobe is latched) and 1-cycle read
    initial begin
        logic [WW-1:0] mem [RS];
        logic wr_q;
        logic [ADW-1:0] wa_q;
        logic [WW-1:0] wd_q;
        wr_q = 1'b0;
        wa_q = '0;
        wd_q = '0;
        for (int i = 0; i < RS; i++) mem[i] = {32'hC0DE_0000 + 32'(i), 4'(i)};
        forever begin
            @(posedge clk);
            if (wr_q) mem[wa_q] <= wd_q;
            if (signal_oe) {fram_data_out, fram_attr_out} <= mem[signal_addr];
            wr_q <= signal_wr;
            wa_q <= signal_addr;
            wd_q <= {fram_data_in, fram_attr_in};
        end
    end

    initial begin
        logic [3:0] rpat;
        int ph;
        rpat = 4'b1001;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? rpat[ph % 4] : 1'($urandom_range(0, 1));
            ph++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [WW-1:0] e;
        logic [ADW+WW-1:0] w;
        int p;
        if (!rst_n) begin
            occ = 0;
            infl = 0;
        end else begin
            p = (m_valid && m_ready) ? 1 : 0;
            chk("m_valid_vs_occupancy", m_valid, occ != 0);
            if (signal_wr || signal_oe) chk("wr_oe_exclusive", signal_wr && signal_oe, 0);
            if (signal_wr) begin
                chk("wr_needs_s_valid", s_valid, 1);
                if (wq.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    w = wq.pop_front();
                    chk("wr_addr", signal_addr, w[WW +: ADW]);
                    chk("wr_word", {fram_data_in, fram_attr_in}, w[WW-1:0]);
                end
                last_wr_cyc = cyc;
            end
            if (signal_oe) chk("oe_while_fifo_full", occ == 2, 0);
            if (p == 1) begin
                if (exp_q.size() == 0) chk("unexpected_m_beat", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("dump_word", {m_data, m_attr}, e);
                end
            end
            occ = occ + infl - p;
            infl = signal_oe ? 1 : 0;
            if (signal_oe) chk("reads_outstanding_le2", occ + infl <= 2, 1);
        end
    end

    task automatic run_cmd(input logic dir, input int base, input int len, input int smode,
                           input int abort, input bit fixed);
        logic [WW-1:0] beat [$];
        logic [4:0] pat;
        int acc, i, k, ph, strobes;
        bit got;
        pat = 5'b01101;
        for (i = 0; i < len; i++)
            beat.push_back(fixed ? {32'hA0 + 32'(i), 4'(i + 1)} : {32'($urandom), 4'($urandom)});
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_dir = dir;
        cmd_base = base[ADW-1:0];
        cmd_len = len[ADW:0];
        got = 0;
        for (k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (cmd_ready) got = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("cmd_accepted", got, 1);
        if (!got) begin
            cmd_valid = 1'b0;
            return;
        end
        acc = cyc;
        for (i = 0; i < len; i++) begin
            if (dir) exp_q.push_back(ref_mem[(base + i) % RS]);
            else wq.push_back({ADW'((base + i) % RS), beat[i]});
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (!dir) begin
            i = 0;
            k = 0;
            ph = 0;
            while (i < len && k < 400) begin
                s_valid = smode == 0 ? 1'b1 : smode == 1 ? pat[ph % 5] : 1'($urandom_range(0, 1));
                ph++;
                {s_data, s_attr} = beat[i];
                if (abort > 0 && i == abort) begin
                    #1;
                    rst_n = 1'b0;
                    #1;
                    chk("rst_busy", busy, 0);
                    chk("rst_s_ready", s_ready, 0);
                    chk("rst_signal_wr", signal_wr, 0);
                    chk("rst_addr", signal_addr, 0);
                    chk("rst_done", done, 0);
                    s_valid = 1'b0;
                    wq.delete();
                    repeat (2) @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    #1;
                    chk("post_rst_cmd_ready", cmd_ready, 1);
                    return;
                end
                @(negedge clk);
                if (s_valid && s_ready) begin
                    ref_mem[(base + i) % RS] = beat[i];
                    i++;
                end
                @(posedge clk);
                #1;
                k++;
            end
            s_valid = 1'b0;
            chk("load_beats_taken", i, len);
        end
        got = 0;
        strobes = 0;
        for (k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (signal_wr || signal_oe) strobes++;
            if (done) got = 1;
        end
        chk("done_seen", got, 1);
        if (got) begin
            chk("busy_during_done", busy, 1);
            if (len == 0) begin
                chk("len0_done_latency", cyc - acc, 1);
                chk("len0_no_mem_access", strobes, 0);
            end else if (!dir) chk("load_drain_cycles", cyc - last_wr_cyc, 2);
            else if (rdy_mode == 0) chk("dump_full_rate_done", cyc - acc, len + 2);
            @(negedge clk);
            chk("idle_after_done", {busy, cmd_ready, done}, 3'b010);
            if (dir) chk("dump_all_popped", exp_q.size(), 0);
            else chk("load_all_written", wq.size(), 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < RS; i++) ref_mem[i] = {32'hC0DE_0000 + 32'(i), 4'(i)};
        #2 rst_n = 1'b0;
        #2;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_s_ready", s_ready, 0);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_wr_oe", {signal_wr, signal_oe}, 0);
        chk("reset_addr", signal_addr, 0);
        chk("reset_m_word", {m_data, m_attr}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_mode = 0;
        run_cmd(1'b0, 14, 4, 0, 0, 1);
        run_cmd(1'b1, 14, 4, 0, 0, 0);
        rdy_mode = 1;
        run_cmd(1'b1, 3, 8, 0, 0, 0);
        rdy_mode = 0;
        run_cmd(1'b0, 5, 0, 0, 0, 0);
        run_cmd(1'b1, 9, 0, 0, 0, 0);
        run_cmd(1'b0, 7, 6, 1, 0, 0);
        rdy_mode = 2;
        run_cmd(1'b1, 7, 6, 0, 0, 0);
        rdy_mode = 0;
        run_cmd(1'b0, 10, 8, 0, 2, 0);
        run_cmd(1'b1, 10, 8, 0, 0, 0);
        run_cmd(1'b1, 0, 16, 0, 0, 0);
        for (int n = 0; n < 30; n++) begin
            rdy_mode = $urandom_range(0, 2);
            run_cmd(1'($urandom_range(0, 1)), $urandom_range(0, RS - 1), $urandom_range(0, RS),
                    $urandom_range(0, 2), 0, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fram_stream_port.md
Name: fram_stream_port

Overview:
- Initiator for the fram signal interface (signal_addr / signal_wr / signal_oe, data_in / attr_in, data_out / attr_out).
- Bridges valid/ready streams into and out of a pu_fram-style memory.
- LOAD command: writes a contiguous block from an input stream into the memory.
- DUMP command: reads a block back out onto an output stream.
- Handles the memory's registered write path, its 1-cycle read latency, and output backpressure.

Parameters:
- RAM_SIZE, 16, words in the attached memory.
- DATA_WIDTH, 32, data word width.
- ATTR_WIDTH, 4, attribute width.
- ADDR_WIDTH, $clog2(RAM_SIZE), memory address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_dir  in  1  0 = LOAD, 1 = DUMP.
- cmd_base  in  ADDR_WIDTH  first address.
- cmd_len  in  ADDR_WIDTH+1  word count, 0..RAM_SIZE.
- s_valid  in  1  load stream valid.
- s_ready  out  1  load stream ready.
- s_data  in  DATA_WIDTH  load data.
- s_attr  in  ATTR_WIDTH  load attribute.
- m_valid  out  1  dump stream valid.
- m_ready  in  1  dump stream ready.
- m_data  out  DATA_WIDTH  dump data.
- m_attr  out  ATTR_WIDTH  dump attribute.
- signal_addr  out  ADDR_WIDTH  memory address.
- signal_wr  out  1  memory write strobe.
- signal_oe  out  1  memory read enable.
- fram_data_in  out  DATA_WIDTH  to memory data_in.
- fram_attr_in  out  ATTR_WIDTH  to memory attr_in.
- fram_data_out  in  DATA_WIDTH  from memory data_out.
- fram_attr_out  in  ATTR_WIDTH  from memory attr_out.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.

Behaviour:
- Reset values: cmd_ready=1, busy=0, done=0, s_ready=0, m_valid=0, signal_wr=0, signal_oe=0, signal_addr=0, m_data/m_attr=0. The skid FIFO is emptied.
- States: IDLE, LOAD, DUMP, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On accept, latch base, len and dir; busy=1 from the next cycle.
  - len=0: go directly to DRAIN with a 0-cycle wait, so done pulses 1 cycle after accept. No memory activity.
- LOAD:
  - s_ready=1.
  - signal_wr = s_valid (combinational); signal_addr = current address; fram_data_in/fram_attr_in = s_data/s_attr.
  - Each handshake increments the address modulo RAM_SIZE (wrap to 0 past RAM_SIZE-1) and decrements the remaining count.
  - After the last beat, enter DRAIN.
- DRAIN:
  - Waits 2 cycles after the last write strobe so the memory's registered write has committed.
  - Then pulses done for 1 cycle, clears busy and returns to IDLE.
  - Guarantees that a DUMP issued immediately afterwards at the same address returns the new data.
- DUMP:
  - signal_oe=1 with signal_addr for one cycle per issued read.
  - Read data appears on fram_data_out the cycle after the issue and is pushed into the skid FIFO that cycle.
  - A read is issued only when (in-flight reads + FIFO occupancy) < 2, so data is never lost under backpressure.
  - m_valid = FIFO not empty; a pop happens on m_valid & m_ready.
  - Ordering is strictly by ascending (wrapped) address.
  - When all len words have been popped, pulse done, clear busy and go to IDLE. No DRAIN wait on dump.
- signal_wr and signal_oe are never high in the same cycle; s_ready=0 outside LOAD.
- cmd_len > RAM_SIZE is illegal. The behaviour is defined as continued wrap: later words overwrite earlier ones, or are re-read.
- A new command is not accepted while busy (cmd_ready=0).
- Reset mid-operation:
  - All outputs return to their reset values immediately (asynchronous).
  - The state returns to IDLE and the FIFO is cleared.
  - A write strobed in the final pre-reset cycle may still commit inside the memory. This is documented and not prevented.
- Throughput: LOAD runs at 1 word/cycle; DUMP runs at 1 word/cycle when m_ready is held high, with first m_valid 2 cycles after entering DUMP.

Decomposition:
- Package fram_stream_pkg: state encoding (IDLE, LOAD, DUMP, DRAIN), DIR_LOAD=0 / DIR_DUMP=1 constants, DRAIN_CYCLES=2.
- Sub-module fram_skid_fifo: 2-entry FIFO of DATA_WIDTH+ATTR_WIDTH bits with push, pop, count, asynchronous active-low reset.
- Top level: FSM, address/count registers, credit logic.

Test Plan:
- LOAD base=14, len=4, data 0xA0..0xA3, attr 1..4, RAM_SIZE=16 -> writes at addresses 14, 15, 0, 1; done pulses 2 cycles after the 4th strobe.
- DUMP base=14, len=4 immediately after the above load -> m_data 0xA0, 0xA1, 0xA2, 0xA3 with attr 1..4 in order; no stale data.
- DUMP len=8 with m_ready toggling 1,0,0,1 repeatedly -> all 8 words delivered in order; no more than 2 reads outstanding; signal_oe never high while the FIFO is full.
- cmd_len=0 in both directions -> done pulses 1 cycle after accept; signal_wr and signal_oe stay 0.
- LOAD len=6 with s_valid gaps (1,0,1,1,0,...) -> signal_wr only on handshake cycles; addresses contiguous.
- rst_n asserted during the 3rd beat of LOAD len=8 -> busy=0, s_ready=0, signal_wr=0 immediately; after release cmd_ready=1 and a fresh DUMP works.
